// File: rtl/spi_pkg.sv
// Shared definitions for the mode-0 SPI initiator.
// Holds the FSM state encoding and the SPI bus mode constants.
package spi_pkg;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        LOW_LAST,
        GAP
    } spi_state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Phase counter for spi_master: phase_end is high for one cycle when the current
// phase has lasted CLK_DIV cycles; restart reloads the count for a fresh phase.
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic phase_end
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("spi_tick_gen: CLK_DIV must be at least 1");
    end

    logic [CW-1:0] cnt;

    // Counts down to zero and parks there; the owner restarts it on every phase change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= RELOAD;
        end else if (restart) begin
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign phase_end = (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI initiator: one DATA_WIDTH-bit transfer per accepted start, spi_sclk divided from clk.
// Build option SPI_MASTER_LSB_FIRST_EN: shift LSB first in both directions (default MSB first).
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx,
    input  logic                  hold_cs,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx,
    output logic                  spi_sclk,
    output logic                  spi_cs_n,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] BITS = BW'(DATA_WIDTH);

    if (DATA_WIDTH < 2) begin : g_bad_width
        $error("spi_master: DATA_WIDTH must be at least 2");
    end
    if (SPI_CPOL != 1'b0 || SPI_CPHA != 1'b0) begin : g_bad_mode
        $error("spi_master: only SPI mode 0 is implemented");
    end

    spi_state_t            state, state_next;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]         bit_cnt;
    logic                  hold_q;
    logic                  accept;
    logic                  restart;
    logic                  phase_end;

    logic                  first_bit;
    logic                  head_bit;
    logic [DATA_WIDTH-1:0] shreg_shifted;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign first_bit     = tx[0];
    assign head_bit      = shreg[0];
    assign shreg_shifted = {spi_miso, shreg[DATA_WIDTH-1:1]};
`else
    assign first_bit     = tx[DATA_WIDTH-1];
    assign head_bit      = shreg[DATA_WIDTH-1];
    assign shreg_shifted = {shreg[DATA_WIDTH-2:0], spi_miso};
`endif

    // Every non-idle phase ends in a state change, so each phase end restarts the counter.
    assign accept  = (state == IDLE) && start;
    assign restart = accept || ((state != IDLE) && phase_end);

    spi_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .restart  (restart),
        .phase_end(phase_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values and updates together.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:     if (start)     state_next = SETUP;
            SETUP:    if (phase_end) state_next = HIGH;
            HIGH:     if (phase_end) state_next = (bit_cnt < BITS) ? LOW : LOW_LAST;
            LOW:      if (phase_end) state_next = HIGH;
            LOW_LAST: if (phase_end) state_next = hold_q ? IDLE : GAP;
            GAP:      if (phase_end) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // bit_cnt counts bits already presented on spi_mosi; the first goes out on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            hold_q   <= 1'b0;
            spi_sclk <= SPI_CPOL;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= tx;
                        hold_q   <= hold_cs;
                        bit_cnt  <= BW'(1);
                        spi_cs_n <= 1'b0;
                        spi_mosi <= first_bit;
                        busy     <= 1'b1;
                    end
                end
                SETUP, LOW: begin
                    if (phase_end) begin
                        spi_sclk <= ~SPI_CPOL;
                        shreg    <= shreg_shifted;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        spi_sclk <= SPI_CPOL;
                        if (bit_cnt < BITS) begin
                            spi_mosi <= head_bit;
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end
                end
                LOW_LAST: begin
                    if (phase_end) begin
                        rx   <= shreg;
                        done <= 1'b1;
                        if (hold_q) begin
                            busy <= 1'b0;
                        end else begin
                            spi_cs_n <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Randomised self-checking bench for spi_master: a cycle-level timeline model derived
// from the phase arithmetic, a bus-side slave monitor, and a CLK_DIV=1 second instance.
`timescale 1ns/1ps
module tb_spi_master;

    localparam int CLK_DIV = 4;
    localparam int W       = 8;
    localparam int XFER    = (2 * W + 1) * CLK_DIV;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] tx = '0;
    logic         hold_cs = 1'b0;
    logic         busy, done;
    logic [W-1:0] rx;
    logic         spi_sclk, spi_cs_n, spi_mosi, spi_miso;

    logic         loopback = 1'b1;
    logic [W-1:0] reply_byte = '0;
    logic         miso_drv = 1'b0;
    assign spi_miso = loopback ? spi_mosi : miso_drv;

    logic         f_start = 1'b0;
    logic [7:0]   f_tx = '0;
    logic         f_hold = 1'b0;
    logic         f_busy, f_done, f_sclk, f_cs_n, f_mosi;
    logic [7:0]   f_rx;

    spi_master #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .tx(tx), .hold_cs(hold_cs),
        .busy(busy), .done(done), .rx(rx), .spi_sclk(spi_sclk),
        .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    spi_master #(.CLK_DIV(1), .DATA_WIDTH(8)) dut_fast (
        .clk(clk), .reset(reset), .start(f_start), .tx(f_tx), .hold_cs(f_hold),
        .busy(f_busy), .done(f_done), .rx(f_rx), .spi_sclk(f_sclk),
        .spi_cs_n(f_cs_n), .spi_mosi(f_mosi), .spi_miso(f_mosi)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bit i of a word in transmission order.
    function automatic logic bit_at(input logic [W-1:0] b, input int i);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return b[i];
`else
        return b[W-1-i];
`endif
    endfunction

    // Timeline model: phase index p = cycles since accept / CLK_DIV. p=0 setup, odd p
    // has sclk high, bit p/2 is on mosi, done at p = 2W+1, optional CLK_DIV-cycle gap.
    int           cyc = 0;
    int           m_a = 0;
    int           mk, mp;
    bit           m_active = 1'b0;
    logic [W-1:0] m_tx = '0, m_reply = '0;
    logic         m_hold = 1'b0;
    logic         e_sclk = 1'b0, e_cs = 1'b1, e_mosi = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    logic [W-1:0] e_rx = '0;
    int           e_bi = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
            e_sclk = 1'b0; e_cs = 1'b1; e_mosi = 1'b0;
            e_busy = 1'b0; e_done = 1'b0; e_rx = '0; e_bi = 0;
        end else begin
            cyc++;
            if (!e_busy && start) begin
                m_active = 1'b1;
                m_a      = cyc;
                m_tx     = tx;
                m_hold   = hold_cs;
                m_reply  = loopback ? tx : reply_byte;
            end
            if (m_active) begin
                mk     = cyc - m_a;
                mp     = mk / CLK_DIV;
                e_sclk = (mp < 2 * W) && (mp % 2 == 1);
                e_bi   = (mp / 2 < W) ? mp / 2 : W - 1;
                e_mosi = bit_at(m_tx, e_bi);
                e_done = (mk == XFER);
                if (e_done) e_rx = m_reply;
                if (mk < XFER) begin
                    e_cs = 1'b0; e_busy = 1'b1;
                end else if (m_hold) begin
                    e_cs = 1'b0; e_busy = 1'b0; m_active = 1'b0;
                end else if (mk < XFER + CLK_DIV) begin
                    e_cs = 1'b1; e_busy = 1'b1;
                end else begin
                    e_cs = 1'b1; e_busy = 1'b0; m_active = 1'b0;
                end
            end else begin
                e_done = 1'b0;
            end
        end
    end

    // Compare process plus slave-side monitor, sampled on the falling edge.
    logic         prev_sclk = 1'b0, prev_mosi = 1'b0;
    int           rises = 0;
    int           done_cnt = 0;
    int           last_lat = -1;
    logic [W-1:0] s_word = '0, s_exp = '0;

    always @(negedge clk) begin
        if (checking && !reset) begin
            check("cs_n", spi_cs_n, e_cs);
            check("sclk", spi_sclk, e_sclk);
            check("mosi", spi_mosi, e_mosi);
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("rx", rx, e_rx);
            if (m_active && cyc == m_a) rises = 0;
            if (!prev_sclk && spi_sclk) begin
                check("mosi_stable_at_rise", spi_mosi, prev_mosi);
                if (rises < W) s_word[rises] = spi_mosi;
                rises++;
            end
            if (spi_mosi !== prev_mosi) check("mosi_moves_sclk_low", spi_sclk, 1'b0);
            if (e_done) begin
                check("sclk_rises", rises, W);
                for (int i = 0; i < W; i++) s_exp[i] = bit_at(m_tx, i);
                check("slave_rx", s_word, s_exp);
            end
            if (done === 1'b1) begin
                done_cnt++;
                last_lat = cyc - m_a;
            end
        end
        prev_sclk = spi_sclk;
        prev_mosi = spi_mosi;
        miso_drv  = m_active ? bit_at(m_reply, e_bi) : 1'b0;
    end

    task automatic xfer(input logic [W-1:0] t, input logic h, input logic lb, input logic [W-1:0] r);
        int n = 0;
        while (e_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("xfer_wait_idle", e_busy, 1'b0);
        start = 1'b1; tx = t; hold_cs = h; loopback = lb; reply_byte = r;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (e_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", e_busy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        #1 reset = 1'b1;
        #12;
        @(negedge clk);
        reset = 1'b0;
        checking = 1'b1;
        check("reset_cs_n", spi_cs_n, 1'b1);
        check("reset_sclk", spi_sclk, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_rx", rx, 8'h00);

        // Single loopback byte: latency 17 * 4 = 68 cycles.
        xfer(8'hF0, 1'b0, 1'b1, 8'h00);
        wait_idle();
        check("t1_rx", rx, 8'hF0);
        check("t1_latency", last_lat, 68);

        // Held chip select across a four-byte frame.
        xfer(8'hF0, 1'b1, 1'b1, 8'h00);
        xfer(8'h0F, 1'b1, 1'b1, 8'h00);
        xfer(8'hF0, 1'b1, 1'b1, 8'h00);
        xfer(8'h0F, 1'b0, 1'b1, 8'h00);
        wait_idle();
        check("t2_rx", rx, 8'h0F);

        // Independent reply on spi_miso.
        xfer(8'h3B, 1'b0, 1'b0, 8'hA5);
        wait_idle();
        check("t3_rx", rx, 8'hA5);

        // Stray start mid-byte is ignored.
        d0 = done_cnt;
        xfer(8'h5A, 1'b0, 1'b1, 8'h00);
        repeat (20) @(negedge clk);
        start = 1'b1; tx = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("t4_rx", rx, 8'h5A);
        check("t4_done_count", done_cnt - d0, 1);

        // Reset after the third sclk rise aborts immediately.
        d0 = done_cnt;
        xfer(8'hC3, 1'b0, 1'b1, 8'h00);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            #1;
            n++;
            if (rises >= 3) break;
        end
        check("t5_third_rise", rises, 3);
        reset = 1'b1;
        #1;
        check("t5_cs_n", spi_cs_n, 1'b1);
        check("t5_sclk", spi_sclk, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_rx", rx, 8'h00);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_no_done", done_cnt - d0, 0);
        xfer(8'h3C, 1'b0, 1'b1, 8'h00);
        wait_idle();
        check("t5_rx_after", rx, 8'h3C);

        // Randomised traffic, stray starts included.
        repeat (3000) begin
            @(negedge clk);
            start   = ($urandom_range(0, 7) == 0);
            tx      = W'($urandom);
            hold_cs = 1'($urandom);
            if (!e_busy) begin
                loopback   = 1'($urandom);
                reply_byte = W'($urandom);
            end
        end
        start = 1'b0;
        wait_idle();

        // CLK_DIV = 1 instance: done after 17 cycles, first bit per build order.
        @(negedge clk);
        f_tx = 8'h01; f_hold = 1'b0; f_start = 1'b1;
        @(posedge clk);
        #1 f_start = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
        check("fast_first_mosi", f_mosi, 1'b1);
`else
        check("fast_first_mosi", f_mosi, 1'b0);
`endif
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (f_done === 1'b1) break;
        end
        check("fast_latency", n, 17);
        check("fast_rx", f_rx, 8'h01);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
